// File: rtl/dl_pkg.sv
// Shared types and memory-map constants for the ROM download sequencer.
// The image is the program ROM followed directly by the vector ROM.
package dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    GAP,
    HOLD,
    DONE
  } dl_state_t;

  localparam int unsigned PROG_ROM_BASE = 'h0000;
  localparam int unsigned VEC_ROM_BASE  = 'h4000;
  localparam int unsigned VEC_ROM_END   = 'h5000;
  localparam int unsigned DL_TOTAL      = VEC_ROM_END;

endpackage

// File: rtl/rom_dl_sequencer_if.sv
// Byte stream from the host loader plus the dl_* write port toward the game top.
// The sequencer uses the slave modport; the host/bridge side uses master.
interface rom_dl_sequencer_if #(
  parameter int unsigned ADDR_W = 25
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_wr;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  dl_addr,
    input  dl_data,
    input  dl_wr
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output dl_addr,
    output dl_data,
    output dl_wr
  );

endinterface

// File: rtl/dl_delay_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Time-shared between the inter-write gap and the post-load reset hold.
module dl_delay_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rom_dl_sequencer.sv
// Turns the host byte stream into single-cycle dl_wr writes at sequential addresses,
// holding the game core in reset for the load and releasing it after a fixed delay.
module rom_dl_sequencer
  import dl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned TOTAL_BYTES = DL_TOTAL,
  parameter int unsigned WR_GAP      = 2,
  parameter int unsigned RESET_HOLD  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  rom_dl_sequencer_if.slave   bus,
  output logic                core_rst_n,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         checksum,
  output logic [ADDR_W-1:0]   byte_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] GAP_LOAD  = (WR_GAP > 0) ? CNT_W'(WR_GAP - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LOAD = (RESET_HOLD > 0) ? CNT_W'(RESET_HOLD - 1) : '0;
  localparam logic [ADDR_W-1:0] TOTAL    = ADDR_W'(TOTAL_BYTES);

  dl_state_t         state_q, state_d;
  dl_state_t         after_write;
  logic [ADDR_W-1:0] dl_addr_q;
  logic [7:0]        dl_data_q;
  logic [ADDR_W-1:0] byte_count_q;
  logic [15:0]       checksum_q;
  logic              last_seen_q;
  logic              error_q;
  logic              core_rst_n_q;

  logic              restart;
  logic              accept;
  logic              fail;
  logic              finish_ok;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              timer_zero;

  dl_delay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Common exit once a byte's write (and its gap) is complete. A full count wins
  // over in_last, so in_last on the final byte is an ordinary finish.
  always_comb begin
    after_write = ACCEPT;
    if (byte_count_q == TOTAL) begin
      after_write = HOLD;
    end else if (last_seen_q) begin
      after_write = DONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    restart    = 1'b0;
    accept     = 1'b0;
    fail       = 1'b0;
    finish_ok  = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ACCEPT;
          restart = 1'b1;
        end
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (WR_GAP > 0) begin
          state_d    = GAP;
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
        end else begin
          state_d = after_write;
          fail    = (after_write == DONE);
        end
      end
      GAP: begin
        if (timer_zero) begin
          state_d = after_write;
          fail    = (after_write == DONE);
        end
      end
      HOLD: begin
        if (timer_zero) begin
          state_d   = DONE;
          finish_ok = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == HOLD && state_q != HOLD) begin
      timer_load = 1'b1;
      timer_val  = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dl_addr_q    <= '0;
      dl_data_q    <= '0;
      byte_count_q <= '0;
      checksum_q   <= '0;
      last_seen_q  <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        byte_count_q <= '0;
        checksum_q   <= '0;
        last_seen_q  <= 1'b0;
        error_q      <= 1'b0;
        core_rst_n_q <= 1'b0;
      end
      if (accept) begin
        dl_data_q    <= bus.in_data;
        dl_addr_q    <= byte_count_q;
        byte_count_q <= byte_count_q + 1'b1;
        checksum_q   <= checksum_q + {8'h00, bus.in_data};
        last_seen_q  <= bus.in_last;
      end
      if (fail) begin
        error_q <= 1'b1;
      end
      if (finish_ok) begin
        core_rst_n_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready = (state_q == ACCEPT);
  assign bus.dl_wr    = (state_q == WRITE);
  assign bus.dl_addr  = dl_addr_q;
  assign bus.dl_data  = dl_data_q;

  assign busy       = (state_q == ACCEPT) || (state_q == WRITE) ||
                      (state_q == GAP) || (state_q == HOLD);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign core_rst_n = core_rst_n_q;
  assign checksum   = checksum_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: three instances with different sizes and gaps,
// one selected at a time through a shared stimulus/observation mux.
module tb_rom_dl_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int         sel;
  logic       rst_all, rst_cmd, start_cmd, v_cmd, last_cmd;
  logic [7:0] d_cmd;
  int         n_tests = 0;
  int         n_fail  = 0;

  rom_dl_sequencer_if #(.ADDR_W(25)) if_a ();
  rom_dl_sequencer_if #(.ADDR_W(25)) if_b ();
  rom_dl_sequencer_if #(.ADDR_W(25)) if_c ();

  logic        rst_a, rst_b, rst_c, start_a, start_b, start_c;
  logic        rstn_a, rstn_b, rstn_c, busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c, err_a, err_b, err_c;
  logic [15:0] sum_a, sum_b, sum_c;
  logic [24:0] cnt_a, cnt_b, cnt_c;

  assign rst_a   = rst_all | ((sel == 0) & rst_cmd);
  assign rst_b   = rst_all | ((sel == 1) & rst_cmd);
  assign rst_c   = rst_all | ((sel == 2) & rst_cmd);
  assign start_a = (sel == 0) & start_cmd;
  assign start_b = (sel == 1) & start_cmd;
  assign start_c = (sel == 2) & start_cmd;

  assign if_a.in_data  = (sel == 0) ? d_cmd : 8'h00;
  assign if_a.in_valid = (sel == 0) & v_cmd;
  assign if_a.in_last  = (sel == 0) & last_cmd;
  assign if_b.in_data  = (sel == 1) ? d_cmd : 8'h00;
  assign if_b.in_valid = (sel == 1) & v_cmd;
  assign if_b.in_last  = (sel == 1) & last_cmd;
  assign if_c.in_data  = (sel == 2) ? d_cmd : 8'h00;
  assign if_c.in_valid = (sel == 2) & v_cmd;
  assign if_c.in_last  = (sel == 2) & last_cmd;

  rom_dl_sequencer #(.ADDR_W(25), .TOTAL_BYTES(1024), .WR_GAP(2), .RESET_HOLD(16)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .bus(if_a), .core_rst_n(rstn_a), .busy(busy_a),
    .done(done_a), .error(err_a), .checksum(sum_a), .byte_count(cnt_a)
  );
  rom_dl_sequencer #(.ADDR_W(25), .TOTAL_BYTES(64), .WR_GAP(2), .RESET_HOLD(16)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .bus(if_b), .core_rst_n(rstn_b), .busy(busy_b),
    .done(done_b), .error(err_b), .checksum(sum_b), .byte_count(cnt_b)
  );
  rom_dl_sequencer #(.ADDR_W(25), .WR_GAP(0)) u_c (
    .clk(clk), .rst(rst_c), .start(start_c), .bus(if_c), .core_rst_n(rstn_c), .busy(busy_c),
    .done(done_c), .error(err_c), .checksum(sum_c), .byte_count(cnt_c)
  );

  logic        o_wr, o_ready, o_rstn, o_busy, o_done, o_err;
  logic [24:0] o_addr, o_cnt;
  logic [7:0]  o_data;
  logic [15:0] o_sum;

  always_comb begin
    o_wr = 1'b0; o_ready = 1'b0; o_rstn = 1'b0; o_busy = 1'b0; o_done = 1'b0; o_err = 1'b0;
    o_addr = '0; o_cnt = '0; o_data = '0; o_sum = '0;
    case (sel)
      0: begin
        o_wr = if_a.dl_wr; o_ready = if_a.in_ready; o_addr = if_a.dl_addr; o_data = if_a.dl_data;
        o_rstn = rstn_a; o_busy = busy_a; o_done = done_a; o_err = err_a;
        o_sum = sum_a; o_cnt = cnt_a;
      end
      1: begin
        o_wr = if_b.dl_wr; o_ready = if_b.in_ready; o_addr = if_b.dl_addr; o_data = if_b.dl_data;
        o_rstn = rstn_b; o_busy = busy_b; o_done = done_b; o_err = err_b;
        o_sum = sum_b; o_cnt = cnt_b;
      end
      default: begin
        o_wr = if_c.dl_wr; o_ready = if_c.in_ready; o_addr = if_c.dl_addr; o_data = if_c.dl_data;
        o_rstn = rstn_c; o_busy = busy_c; o_done = done_c; o_err = err_c;
        o_sum = sum_c; o_cnt = cnt_c;
      end
    endcase
  end

  logic [24:0] pw_addr[$];
  logic [7:0]  pw_data[$];
  int          pw_cyc[$];
  int          adj_viol, ready_viol, rise_cyc;
  bit          timed_out, saw_done;

  task automatic do_start();
    @(negedge clk);
    start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
  endtask

  task automatic reset_sel();
    @(negedge clk);
    rst_cmd = 1'b1;
    @(negedge clk);
    rst_cmd = 1'b0;
  endtask

  // Offers bytes i[7:0] for i < n_offer and records every dl_wr pulse. Returns 20 cycles
  // after done, or on the first non-write cycle once stop_pulses pulses have been seen.
  task automatic stream(input int n_offer, input int last_idx, input bit rand_valid,
                        input int gap, input int stop_pulses, input int start_cyc,
                        input int budget);
    int i, tail, last_w;
    bit pv, pr, prev_wr;
    i = 0; tail = 0; last_w = -1000; pv = 0; pr = 0; prev_wr = 0;
    pw_addr.delete(); pw_data.delete(); pw_cyc.delete();
    adj_viol = 0; ready_viol = 0; rise_cyc = -1; timed_out = 0; saw_done = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pv && pr) i++;
      if (o_wr) begin
        if (prev_wr) adj_viol++;
        if (o_ready) ready_viol++;
        pw_addr.push_back(o_addr);
        pw_data.push_back(o_data);
        pw_cyc.push_back(c);
        last_w = c;
      end else if ((c - last_w) <= gap && o_ready) begin
        ready_viol++;
      end
      prev_wr = o_wr;
      if (pw_cyc.size() > 0 && o_rstn === 1'b1 && rise_cyc < 0) rise_cyc = c;
      if (o_done) saw_done = 1;
      if (saw_done) tail++;
      if ((stop_pulses > 0 && pw_cyc.size() == stop_pulses && !o_wr) || tail > 20) begin
        v_cmd = 1'b0; last_cmd = 1'b0; start_cmd = 1'b0;
        return;
      end
      start_cmd = (c == start_cyc);
      pv = (i < n_offer) && (!rand_valid || $urandom_range(0, 1) == 1);
      pr = o_ready;
      v_cmd = pv; d_cmd = i[7:0]; last_cmd = (i == last_idx);
    end
    timed_out = 1; v_cmd = 1'b0; last_cmd = 1'b0; start_cmd = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      n_tests++;
      if ({o_wr, o_ready, o_rstn, o_busy, o_done, o_err, o_addr, o_cnt, o_data, o_sum} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs inst %0d: wr=%b rdy=%b rstn=%b busy=%b done=%b err=%b addr=%0h cnt=%0h data=%0h sum=%0h, required all 0",
                 k, o_wr, o_ready, o_rstn, o_busy, o_done, o_err, o_addr, o_cnt, o_data, o_sum);
      end
    end
  endtask

  task automatic test_start_with_valid_idle();
    int wr_seen;
    sel = 0;
    @(negedge clk);
    start_cmd = 1'b1; v_cmd = 1'b1; d_cmd = 8'hAA; last_cmd = 1'b0;
    n_tests++;
    if (o_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready: got %b required 0", o_ready);
    end
    @(negedge clk);
    start_cmd = 1'b0; v_cmd = 1'b0;
    n_tests++;
    if (o_busy !== 1'b1 || o_rstn !== 1'b0) begin
      n_fail++; $display("FAIL start_enter_accept: busy=%b rstn=%b required 1/0", o_busy, o_rstn);
    end
    wr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_wr) wr_seen++;
    end
    n_tests++;
    if (wr_seen != 0 || o_cnt !== 25'd0) begin
      n_fail++; $display("FAIL start_byte_not_consumed: wr=%0d cnt=%0d required 0/0", wr_seen, o_cnt);
    end
    reset_sel();
  endtask

  task automatic test_early_last();
    sel = 0;
    do_start();
    stream(150, 99, 1'b0, 2, 0, -1, 2000);
    n_tests++;
    if (timed_out || pw_cyc.size() != 100) begin
      n_fail++; $display("FAIL early_last_pulses: got %0d (timeout=%0b) required 100", pw_cyc.size(), timed_out);
    end
    n_tests++;
    if (o_cnt !== 25'd100 || o_err !== 1'b1 || o_done !== 1'b1) begin
      n_fail++; $display("FAIL early_last_status: cnt=%0d err=%b done=%b required 100/1/1", o_cnt, o_err, o_done);
    end
    n_tests++;
    if (o_rstn !== 1'b0 || rise_cyc != -1) begin
      n_fail++; $display("FAIL early_last_core_rst: rstn=%b rise=%0d required 0/-1", o_rstn, rise_cyc);
    end
    n_tests++;
    if (o_sum !== 16'h1356) begin
      n_fail++; $display("FAIL early_last_checksum: got %h required 1356", o_sum);
    end
  endtask

  task automatic test_reset_mid_gap();
    int wr_seen, bad_sp, bad_ad;
    sel = 0;
    do_start();
    stream(1024, -1, 1'b0, 2, 501, -1, 4000);
    n_tests++;
    if (timed_out || pw_cyc.size() != 501 || o_cnt !== 25'd501) begin
      n_fail++; $display("FAIL gap_reach: pulses=%0d cnt=%0d required 501/501", pw_cyc.size(), o_cnt);
    end
    rst_cmd = 1'b1;
    @(negedge clk);
    rst_cmd = 1'b0;
    n_tests++;
    if ({o_wr, o_ready, o_rstn, o_busy, o_done, o_err, o_addr, o_cnt, o_data, o_sum} !== '0) begin
      n_fail++;
      $display("FAIL mid_gap_reset: wr=%b rdy=%b rstn=%b busy=%b done=%b err=%b addr=%0h cnt=%0h data=%0h sum=%0h, required all 0",
               o_wr, o_ready, o_rstn, o_busy, o_done, o_err, o_addr, o_cnt, o_data, o_sum);
    end
    wr_seen = 0;
    for (int k = 0; k < 20; k++) begin
      v_cmd = 1'b1; d_cmd = 8'h55;
      @(negedge clk);
      if (o_wr) wr_seen++;
    end
    v_cmd = 1'b0;
    n_tests++;
    if (wr_seen != 0 || o_cnt !== 25'd0) begin
      n_fail++; $display("FAIL post_reset_quiet: wr=%0d cnt=%0d required 0/0", wr_seen, o_cnt);
    end
    do_start();
    stream(1024, 1023, 1'b0, 2, 0, -1, 6000);
    bad_sp = 0; bad_ad = 0;
    for (int k = 0; k < pw_cyc.size(); k++) begin
      if (pw_addr[k] != 25'(k) || pw_data[k] != 8'(k)) bad_ad++;
      if (k > 0 && pw_cyc[k] - pw_cyc[k-1] != 4) bad_sp++;
    end
    n_tests++;
    if (timed_out || pw_cyc.size() != 1024 || bad_ad != 0) begin
      n_fail++; $display("FAIL reload_pulses: got %0d pulses, %0d bad addr/data, required 1024/0", pw_cyc.size(), bad_ad);
    end
    n_tests++;
    if (bad_sp != 0) begin
      n_fail++; $display("FAIL reload_spacing4: %0d gaps not 4 cycles, required 0", bad_sp);
    end
    n_tests++;
    if (o_sum !== 16'hFE00 || o_done !== 1'b1 || o_err !== 1'b0 || o_rstn !== 1'b1) begin
      n_fail++; $display("FAIL reload_status: sum=%h done=%b err=%b rstn=%b required FE00/1/0/1", o_sum, o_done, o_err, o_rstn);
    end
  endtask

  task automatic test_random_valid();
    int bad_ad, bad_sp;
    sel = 1;
    do_start();
    stream(70, -1, 1'b1, 2, 0, -1, 3000);
    bad_ad = 0; bad_sp = 0;
    for (int k = 0; k < pw_cyc.size(); k++) begin
      if (pw_addr[k] != 25'(k) || pw_data[k] != 8'(k)) bad_ad++;
      if (k > 0 && pw_cyc[k] - pw_cyc[k-1] < 4) bad_sp++;
    end
    n_tests++;
    if (timed_out || pw_cyc.size() != 64 || bad_ad != 0) begin
      n_fail++; $display("FAIL random_pulses: got %0d pulses, %0d dup/skip, required 64/0", pw_cyc.size(), bad_ad);
    end
    n_tests++;
    if (adj_viol != 0 || bad_sp != 0) begin
      n_fail++; $display("FAIL random_adjacent_wr: adj=%0d short=%0d required 0/0", adj_viol, bad_sp);
    end
    n_tests++;
    if (ready_viol != 0) begin
      n_fail++; $display("FAIL random_ready_in_write_gap: got %0d required 0", ready_viol);
    end
    n_tests++;
    if (o_sum !== 16'h07E0 || o_cnt !== 25'd64 || o_rstn !== 1'b1) begin
      n_fail++; $display("FAIL random_status: sum=%h cnt=%0d rstn=%b required 07E0/64/1", o_sum, o_cnt, o_rstn);
    end
  endtask

  task automatic test_restart_from_done();
    sel = 1;
    do_start();
    n_tests++;
    if (o_rstn !== 1'b0 || o_sum !== 16'h0 || o_cnt !== 25'd0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL restart_clear: rstn=%b sum=%h cnt=%0d done=%b required 0/0/0/0", o_rstn, o_sum, o_cnt, o_done);
    end
    stream(64, 63, 1'b0, 2, 0, -1, 2000);
    n_tests++;
    if (timed_out || pw_cyc.size() != 64 || pw_addr[0] !== 25'd0 || o_sum !== 16'h07E0 || o_rstn !== 1'b1) begin
      n_fail++; $display("FAIL restart_reload: pulses=%0d sum=%h rstn=%b required 64/07E0/1", pw_cyc.size(), o_sum, o_rstn);
    end
  endtask

  task automatic test_start_ignored();
    int bad_ad, bad_sp;
    sel = 2;
    do_start();
    stream('h5000, -1, 1'b0, 0, 200, 50, 1000);
    bad_ad = 0; bad_sp = 0;
    for (int k = 0; k < pw_cyc.size(); k++) begin
      if (pw_addr[k] != 25'(k)) bad_ad++;
      if (k > 0 && pw_cyc[k] - pw_cyc[k-1] != 2) bad_sp++;
    end
    n_tests++;
    if (timed_out || o_cnt !== 25'd200 || bad_ad != 0 || o_sum !== 16'h4DBC) begin
      n_fail++; $display("FAIL start_while_busy: cnt=%0d bad_addr=%0d sum=%h required 200/0/4DBC", o_cnt, bad_ad, o_sum);
    end
    n_tests++;
    if (bad_sp != 0) begin
      n_fail++; $display("FAIL gap0_spacing2: %0d gaps not 2 cycles, required 0", bad_sp);
    end
    reset_sel();
  endtask

  task automatic test_full_load();
    int bad_ad, bad_sp, w;
    sel = 2;
    do_start();
    stream('h5000, 'h4FFF, 1'b0, 0, 0, -1, 42000);
    bad_ad = 0; bad_sp = 0;
    for (int k = 0; k < pw_cyc.size(); k++) begin
      if (pw_addr[k] != 25'(k) || pw_data[k] != 8'(k)) bad_ad++;
      if (k > 0 && pw_cyc[k] - pw_cyc[k-1] != 2) bad_sp++;
    end
    w = (pw_cyc.size() > 0) ? pw_cyc[pw_cyc.size()-1] : -1;
    n_tests++;
    if (timed_out || pw_cyc.size() != 'h5000 || bad_ad != 0) begin
      n_fail++; $display("FAIL full_pulses: got %0h pulses, %0d bad addr/data, required 5000/0", pw_cyc.size(), bad_ad);
    end
    n_tests++;
    if (bad_sp != 0 || adj_viol != 0) begin
      n_fail++; $display("FAIL full_spacing: %0d bad gaps, %0d adjacent, required 0/0", bad_sp, adj_viol);
    end
    n_tests++;
    if (o_sum !== 16'hD800 || o_cnt !== 25'h5000) begin
      n_fail++; $display("FAIL full_checksum: sum=%h cnt=%0h required D800/5000", o_sum, o_cnt);
    end
    n_tests++;
    if (rise_cyc - w != 17) begin
      n_fail++; $display("FAIL full_core_rst_delay: low for %0d cycles after last write, required 16", rise_cyc - w - 1);
    end
    n_tests++;
    if (o_done !== 1'b1 || o_err !== 1'b0 || o_rstn !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL full_status: done=%b err=%b rstn=%b busy=%b required 1/0/1/0", o_done, o_err, o_rstn, o_busy);
    end
  endtask

  initial begin
    sel = 0; rst_cmd = 1'b0; start_cmd = 1'b0; v_cmd = 1'b0; last_cmd = 1'b0; d_cmd = 8'h00;
    rst_all = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_all = 1'b0;
    test_start_with_valid_idle();
    test_early_last();
    test_reset_mid_gap();
    test_random_valid();
    test_restart_from_done();
    test_start_ignored();
    test_full_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
